sdram_mem_tester: RTL and testbench
===================================

// Module: sdram_mem_tester
// PURPOSE
//  Client-side initiator for the SDRAM controller's req/ack client port. On start, writes an
//  address-derived pattern to every word in [ADDR_FIRST..ADDR_LAST], reads all back, and compares.
//  Reports pass/fail, an error count and the first failing address/data for board bring-up.
// PARAMETERS
//  ADDR_WIDTH      22        client address width ({bank,row,col})
//  DATA_WIDTH      16        client data width
//  ADDR_FIRST      0         first word address tested
//  ADDR_LAST       2^22-1    last word address tested (inclusive, >= ADDR_FIRST)
//  WR_HOLD_CYCLES  4         cycles addr/data held after write ack
//  TIMEOUT_CYCLES  1024      max wait for ack or read data
//  ERR_CNT_WIDTH   16        error counter width
// PORTS
//  clk             in   1           system clock (same domain as controller)
//  reset_l         in   1           async reset, active low
//  start           in   1           pulse: begin a test run
//  seed            in   DATA_WIDTH  pattern seed, sampled on accepted start
//  busy            out  1           run in progress
//  done            out  1           run finished; level, held until next accepted start
//  pass            out  1           valid while done: 1 = no errors, no timeout
//  timeout         out  1           valid while done: run aborted on timeout
//  err_count       out  ERR_CNT_WIDTH  read-compare mismatches, saturating
//  first_err_addr  out  ADDR_WIDTH  address of first mismatch
//  first_err_data  out  DATA_WIDTH  data read at first mismatch
//  sdram_req       out  1           request to controller
//  sdram_ack       in   1           one-cycle accept pulse from controller
//  sdram_addr      out  ADDR_WIDTH  word address
//  sdram_rh_wl     out  1           1 = read, 0 = write
//  sdram_data_w    out  DATA_WIDTH  write data
//  sdram_data_r    in   DATA_WIDTH  read data
//  sdram_data_r_en in   1           read data valid pulse
// BEHAVIOUR
//  Reset is asynchronous, active low, on clk; clk and reset_l as stated.
//  Reset values: all outputs 0, FSM in IDLE.
//  Pattern: pat(a) = seed_q ^ a[DATA_WIDTH-1:0] ^ zero-extended a[ADDR_WIDTH-1:DATA_WIDTH].
//   Requires ADDR_WIDTH <= 2*DATA_WIDTH.
//  FSM states: IDLE, WR_REQ, WR_HOLD, RD_REQ, RD_WAIT, FIN.
//  IDLE: start=1 -> seed_q<=seed, addr<=ADDR_FIRST, err_count/first_err*/timeout<=0,
//   done<=0, busy<=1 -> WR_REQ. start while busy is ignored.
//  WR_REQ: sdram_req=1, rh_wl=0, addr, data_w=pat(addr).
//   On ack: req<=0 in the next cycle -> WR_HOLD.
//  WR_HOLD: addr/data held WR_HOLD_CYCLES cycles. Then if addr==ADDR_LAST -> addr<=ADDR_FIRST,
//   RD_REQ; else addr+1 -> WR_REQ.
//  RD_REQ: req=1, rh_wl=1; on ack: req<=0 -> RD_WAIT.
//  RD_WAIT: on data_r_en, compare data_r with pat(addr). On mismatch: err_count+1 (saturating
//   at all-ones); first mismatch of the run also latches first_err_addr/data.
//   Then if addr==ADDR_LAST -> FIN; else addr+1 -> RD_REQ.
//  sdram_addr/rh_wl/data_w stay stable from req rise until WR_HOLD end or data_r_en.
//   req is never high in the cycle after ack.
//  Watchdog: counter cleared on state entry; counts in WR_REQ, RD_REQ and RD_WAIT.
//   Reaching TIMEOUT_CYCLES: timeout<=1, req<=0 -> FIN.
//  FIN (1 cycle): busy<=0, done<=1, pass<=(err_count==0 && !timeout) -> IDLE.
//  ack outside the *_REQ states and data_r_en outside RD_WAIT are ignored.
//  No address wrap: termination is by equality with ADDR_LAST.
//  Reset mid-run: immediate abort; req drops asynchronously; results are cleared.
// STRUCTURE
//  Package sdram_test_pkg: FSM state encodings and the pat() function.
//  Sub-module sdram_tester_watchdog: load/clear, enable, expiry flag, width $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  Bench uses a controller BFM: ack 2 cycles after req; data_r_en 4 cycles after read ack;
//   backing array.
//  1 ADDR_LAST=15, seed=16'hA5A5, clean BFM -> 16 writes then 16 reads; done=1, pass=1, err_count=0.
//  2 BFM flips bit0 on reads of addr 5 and 9 -> err_count=2, first_err_addr=5,
//    first_err_data=pat(5)^1, pass=0.
//  3 BFM never acks the 3rd write -> after 1024 cycles timeout=1, pass=0, done=1, req=0.
//  4 start pulsed mid-run, then again after done -> first ignored; second restarts and clears results.
//  5 reset_l low during RD_WAIT -> outputs 0 immediately; new start runs cleanly to pass=1.
//  6 ADDR_FIRST=ADDR_LAST=2^22-1 -> exactly 1 write + 1 read; addr never wraps to 0; pass=1.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// Shared FSM encodings and the address-derived test pattern
// for the SDRAM bring-up memory tester.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_HOLD,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FIN
  } state_t;

  // Low data-width slice of the address xor the folded upper bits.
  function automatic logic [63:0] pat(
    input logic [63:0] seed,
    input logic [63:0] addr,
    input int unsigned dw
  );
    logic [63:0] mask;
    mask = (64'd1 << dw) - 64'd1;
    return (seed ^ (addr & mask) ^ (addr >> dw)) & mask;
  endfunction

endpackage

// File: rtl/sdram_tester_watchdog.sv
// Wait-state watchdog: cleared on state entry, counts while
// enabled and flags expiry once TIMEOUT_CYCLES is reached.
module sdram_tester_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_l,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expired = en && (r_cnt == LIMIT);

endmodule

// File: rtl/sdram_mem_tester.sv
// Write-all / read-all pattern tester driving the SDRAM
// controller client port; reports pass/fail and first error.
module sdram_mem_tester
  import sdram_test_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1,
  parameter int WR_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_data,
  output logic                     sdram_req,
  input  logic                     sdram_ack,
  output logic [ADDR_WIDTH-1:0]    sdram_addr,
  output logic                     sdram_rh_wl,
  output logic [DATA_WIDTH-1:0]    sdram_data_w,
  input  logic [DATA_WIDTH-1:0]    sdram_data_r,
  input  logic                     sdram_data_r_en
);

  localparam int HOLD_LAST = (WR_HOLD_CYCLES > 0) ? WR_HOLD_CYCLES - 1 : 0;
  localparam int HW = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  state_t                   r_state;
  state_t                   w_next;
  logic [DATA_WIDTH-1:0]    r_seed;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [HW-1:0]            r_hold;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_pass;
  logic                     r_timeout;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [ADDR_WIDTH-1:0]    r_fe_addr;
  logic [DATA_WIDTH-1:0]    r_fe_data;

  logic [DATA_WIDTH-1:0] w_pat;
  logic w_last;
  logic w_hold_done;
  logic w_wd_en;
  logic w_wd_clr;
  logic w_expired;
  logic w_wd_to;

  assign w_pat = DATA_WIDTH'(pat(64'(r_seed), 64'(r_addr), DATA_WIDTH));
  assign w_last = (r_addr == ADDR_LAST);
  assign w_hold_done = (r_hold == HW'(HOLD_LAST));
  assign w_wd_en = (r_state == ST_WR_REQ) ||
                   (r_state == ST_RD_REQ) ||
                   (r_state == ST_RD_WAIT);
  assign w_wd_clr = (w_next != r_state);

  sdram_tester_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .reset_l(reset_l),
    .clr    (w_wd_clr),
    .en     (w_wd_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_wd_to = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (sdram_ack) begin
          w_next = ST_WR_HOLD;
        end else if (w_expired) begin
          w_next  = ST_FIN;
          w_wd_to = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        if (w_hold_done) w_next = w_last ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_RD_REQ: begin
        if (sdram_ack) begin
          w_next = ST_RD_WAIT;
        end else if (w_expired) begin
          w_next  = ST_FIN;
          w_wd_to = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (sdram_data_r_en) begin
          w_next = w_last ? ST_FIN : ST_RD_REQ;
        end else if (w_expired) begin
          w_next  = ST_FIN;
          w_wd_to = 1'b1;
        end
      end
      ST_FIN: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_seed      <= '0;
      r_addr      <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_count <= '0;
      r_fe_addr   <= '0;
      r_fe_data   <= '0;
    end else begin
      r_hold <= (r_state == ST_WR_HOLD) ? r_hold + HW'(1) : '0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_seed      <= seed;
            r_addr      <= ADDR_FIRST;
            r_err_count <= '0;
            r_fe_addr   <= '0;
            r_fe_data   <= '0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_WR_HOLD: begin
          if (w_hold_done) r_addr <= w_last ? ADDR_FIRST : r_addr + 1'b1;
        end
        ST_RD_WAIT: begin
          if (sdram_data_r_en) begin
            if (sdram_data_r != w_pat) begin
              if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
              // Zero count means this is the run's first mismatch.
              if (r_err_count == '0) begin
                r_fe_addr <= r_addr;
                r_fe_data <= sdram_data_r;
              end
            end
            if (!w_last) r_addr <= r_addr + 1'b1;
          end
        end
        ST_FIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (r_err_count == '0) && !r_timeout;
        end
        default: ;
      endcase
      if (w_wd_to) r_timeout <= 1'b1;
    end
  end

  // Request and direction decode straight from state so reset drops them at once.
  assign sdram_req    = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
  assign sdram_rh_wl  = (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT);
  assign sdram_addr   = r_addr;
  assign sdram_data_w = w_pat;

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_count      = r_err_count;
  assign first_err_addr = r_fe_addr;
  assign first_err_data = r_fe_data;

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Bench for sdram_mem_tester: controller BFM with backing
// store, vector table of full runs plus directed corner cases.
module tb_sdram_mem_tester;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  logic        start [2];
  logic [15:0] seed  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        pass  [2];
  logic        tmo   [2];
  logic [15:0] err   [2];
  logic [21:0] fea   [2];
  logic [15:0] fed   [2];
  logic        req   [2];
  logic        ack   [2];
  logic [21:0] addr  [2];
  logic        rh    [2];
  logic [15:0] dw    [2];
  logic [15:0] dr    [2];
  logic        den   [2];

  sdram_mem_tester #(
    .ADDR_FIRST(22'd0),
    .ADDR_LAST (22'd15)
  ) dut0 (
    .clk            (clk),
    .reset_l        (reset_l),
    .start          (start[0]),
    .seed           (seed[0]),
    .busy           (busy[0]),
    .done           (done[0]),
    .pass           (pass[0]),
    .timeout        (tmo[0]),
    .err_count      (err[0]),
    .first_err_addr (fea[0]),
    .first_err_data (fed[0]),
    .sdram_req      (req[0]),
    .sdram_ack      (ack[0]),
    .sdram_addr     (addr[0]),
    .sdram_rh_wl    (rh[0]),
    .sdram_data_w   (dw[0]),
    .sdram_data_r   (dr[0]),
    .sdram_data_r_en(den[0])
  );

  sdram_mem_tester #(
    .ADDR_FIRST(22'h3FFFFF),
    .ADDR_LAST (22'h3FFFFF)
  ) dut1 (
    .clk            (clk),
    .reset_l        (reset_l),
    .start          (start[1]),
    .seed           (seed[1]),
    .busy           (busy[1]),
    .done           (done[1]),
    .pass           (pass[1]),
    .timeout        (tmo[1]),
    .err_count      (err[1]),
    .first_err_addr (fea[1]),
    .first_err_data (fed[1]),
    .sdram_req      (req[1]),
    .sdram_ack      (ack[1]),
    .sdram_addr     (addr[1]),
    .sdram_rh_wl    (rh[1]),
    .sdram_data_w   (dw[1]),
    .sdram_data_r   (dr[1]),
    .sdram_data_r_en(den[1])
  );

  logic        flip = 1'b0;
  logic        blk  = 1'b0;
  logic [15:0] mem [2][16];
  int          cnt [2];
  int          rcnt [2];
  logic [21:0] raddr [2];
  int          run_wr [2];
  int          wr_acks [2];
  int          rd_acks [2];
  logic        ack_d [2];
  int          viol = 0;
  int          bad1 = 0;

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int g = 0; g < 2; g++) begin
        ack[g]    <= 1'b0;
        den[g]    <= 1'b0;
        dr[g]     <= '0;
        cnt[g]    <= 0;
        rcnt[g]   <= 0;
        run_wr[g] <= 0;
        ack_d[g]  <= 1'b0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        ack[g]   <= 1'b0;
        den[g]   <= 1'b0;
        ack_d[g] <= ack[g];
        if (ack_d[g] && req[g]) viol <= viol + 1;
        if (g == 1 && req[g] && addr[g] != 22'h3FFFFF) bad1 <= bad1 + 1;
        if (!busy[g]) run_wr[g] <= 0;
        if (req[g] && !ack[g]) begin
          if (!(blk && g == 0 && !rh[g] && run_wr[g] == 2)) begin
            if (cnt[g] == 1) begin
              ack[g] <= 1'b1;
              cnt[g] <= 0;
              if (!rh[g]) begin
                mem[g][addr[g][3:0]] <= dw[g];
                run_wr[g]  <= run_wr[g] + 1;
                wr_acks[g] <= wr_acks[g] + 1;
              end else begin
                rd_acks[g] <= rd_acks[g] + 1;
                raddr[g]   <= addr[g];
                rcnt[g]    <= 4;
              end
            end else begin
              cnt[g] <= cnt[g] + 1;
            end
          end
        end else if (!req[g]) begin
          cnt[g] <= 0;
        end
        if (rcnt[g] != 0) begin
          rcnt[g] <= rcnt[g] - 1;
          if (rcnt[g] == 1) begin
            den[g] <= 1'b1;
            dr[g]  <= mem[g][raddr[g][3:0]] ^
                      {15'd0, flip && (raddr[g] == 22'd5 || raddr[g] == 22'd9)};
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] tpat(input logic [15:0] s,
                                       input logic [21:0] a);
    return s ^ a[15:0] ^ {10'd0, a[21:16]};
  endfunction

  function automatic logic any_out(input int g);
    return |{busy[g], done[g], pass[g], tmo[g], err[g], fea[g], fed[g],
             req[g], addr[g], rh[g], dw[g]};
  endfunction

  task automatic go(input int g, input logic [15:0] s);
    seed[g]  = s;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int lim);
    int n;
    n = 0;
    while (!done[g] && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_done%0d", g), done[g], 1'b1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] seed;
    logic        flip;
    logic        blk;
    logic        pass;
    logic        tmo;
    logic [15:0] err;
    logic [21:0] fea;
    logic [15:0] fed;
    int          wr;
    int          rd;
  } vec_t;

  vec_t vecs [3];
  int   w0;
  int   r0;
  int   n;

  initial begin
    vecs[0] = '{"clean", 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0,
                16'd0, 22'd0, 16'h0000, 16, 16};
    vecs[1] = '{"flip", 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0,
                16'd2, 22'd5, 16'hA5A1, 16, 16};
    vecs[2] = '{"noack", 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1,
                16'd0, 22'd0, 16'h0000, 2, 0};
    for (int g = 0; g < 2; g++) begin
      start[g]   = 1'b0;
      seed[g]    = '0;
      wr_acks[g] = 0;
      rd_acks[g] = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset_out0", any_out(0), 1'b0);
    chk("reset_out1", any_out(1), 1'b0);
    reset_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      flip = vecs[i].flip;
      blk  = vecs[i].blk;
      w0 = wr_acks[0];
      r0 = rd_acks[0];
      go(0, vecs[i].seed);
      wait_done(0, 5000);
      chk({vecs[i].name, ".pass"}, pass[0], vecs[i].pass);
      chk({vecs[i].name, ".timeout"}, tmo[0], vecs[i].tmo);
      chk({vecs[i].name, ".err"}, err[0], vecs[i].err);
      chk({vecs[i].name, ".fea"}, fea[0], vecs[i].fea);
      chk({vecs[i].name, ".fed"}, fed[0], vecs[i].fed);
      chk({vecs[i].name, ".busy"}, busy[0], 1'b0);
      chk({vecs[i].name, ".req"}, req[0], 1'b0);
      chk({vecs[i].name, ".wr"}, 64'(wr_acks[0] - w0), 64'(vecs[i].wr));
      chk({vecs[i].name, ".rd"}, 64'(rd_acks[0] - r0), 64'(vecs[i].rd));
      @(negedge clk);
    end
    blk = 1'b0;

    // start while busy must be ignored
    flip = 1'b1;
    go(0, 16'h0F0F);
    repeat (40) @(negedge clk);
    go(0, 16'hFFFF);
    chk("mid.busy", busy[0], 1'b1);
    wait_done(0, 5000);
    chk("mid.err", err[0], 16'd2);
    chk("mid.fea", fea[0], 22'd5);
    chk("mid.fed", fed[0], tpat(16'h0F0F, 22'd5) ^ 16'd1);
    chk("mid.mem3", mem[0][3], tpat(16'h0F0F, 22'd3));
    chk("mid.mem15", mem[0][15], tpat(16'h0F0F, 22'd15));
    flip = 1'b0;
    go(0, 16'h7E7E);
    chk("restart.done", done[0], 1'b0);
    chk("restart.err", err[0], 16'd0);
    chk("restart.fea", fea[0], 22'd0);
    chk("restart.busy", busy[0], 1'b1);
    wait_done(0, 5000);
    chk("restart.pass", pass[0], 1'b1);

    // async reset while waiting for read data
    go(0, 16'h3C3C);
    n = 0;
    while (!(rh[0] && !req[0]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("found_rd_wait", rh[0] && !req[0], 1'b1);
    #2 reset_l = 1'b0;
    #1 chk("async_rst_out", any_out(0), 1'b0);
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    go(0, 16'h3C3C);
    wait_done(0, 5000);
    chk("post_rst.pass", pass[0], 1'b1);
    chk("post_rst.err", err[0], 16'd0);

    // single-word run at the top address
    w0 = wr_acks[1];
    r0 = rd_acks[1];
    go(1, 16'h5A5A);
    wait_done(1, 2000);
    chk("top.pass", pass[1], 1'b1);
    chk("top.wr", 64'(wr_acks[1] - w0), 64'd1);
    chk("top.rd", 64'(rd_acks[1] - r0), 64'd1);
    chk("top.nowrap", 64'(bad1), 64'd0);
    chk("top.addr", addr[1], 22'h3FFFFF);
    chk("top.mem", mem[1][15], tpat(16'h5A5A, 22'h3FFFFF));

    chk("req_after_ack", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
